// File: rtl/ads5296_train_ctrl.sv
// ADS5296 LVDS link training: per-channel delay-tap eye sweep, centring and
// word alignment via bitslip, with per-channel centre taps and a failure mask.
module ads5296_train_ctrl #(
    parameter int         G_NUM_UNITS = 4,
    parameter logic [9:0] G_PATTERN   = 10'h3F0,
    parameter int         G_TAP_STEP  = 8,
    parameter int         G_CHECK_LEN = 64,
    parameter int         G_PULSE_LEN = 8,
    parameter int         G_SETTLE    = 16,
    localparam int        C           = 4 * G_NUM_UNITS,
    localparam int        CW          = $clog2(C)
) (
    input  logic           axil_clk,
    input  logic           axil_rst_n,
    input  logic           start,
    input  logic [9:0]     data_in,
    input  logic           data_valid,
    output logic [CW-1:0]  chan_sel,
    output logic [8:0]     delay_val,
    output logic [2*C-1:0] delay_load,
    output logic [C-1:0]   bitslip,
    output logic           busy,
    output logic           done,
    output logic [C-1:0]   fail_mask,
    input  logic [CW-1:0]  result_sel,
    output logic [8:0]     result_tap
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_SET_TAP = 4'd1;
    localparam logic [3:0] S_LOAD    = 4'd2;
    localparam logic [3:0] S_SETTLE  = 4'd3;
    localparam logic [3:0] S_CHECK   = 4'd4;
    localparam logic [3:0] S_EVAL    = 4'd5;
    localparam logic [3:0] S_CENTER  = 4'd6;
    localparam logic [3:0] S_CLOAD   = 4'd7;
    localparam logic [3:0] S_CSETTLE = 4'd8;
    localparam logic [3:0] S_ACHECK  = 4'd9;
    localparam logic [3:0] S_SLIP    = 4'd10;
    localparam logic [3:0] S_SSETTLE = 4'd11;
    localparam logic [3:0] S_NEXT_CH = 4'd12;
    localparam logic [3:0] S_DONE    = 4'd13;

    localparam logic [15:0]    PULSE_CNT   = 16'(G_PULSE_LEN);
    localparam logic [15:0]    SETTLE_LAST = 16'(G_SETTLE - 1);
    localparam logic [15:0]    CHECK_LAST  = 16'(G_CHECK_LEN - 1);
    localparam logic [9:0]     TAP_STEP    = 10'(G_TAP_STEP);
    localparam logic [CW-1:0]  LAST_CH     = CW'(C - 1);
    localparam logic [2*C-1:0] LANE0       = {{(2*C-2){1'b0}}, 2'b11};
    localparam logic [C-1:0]   CH0         = {{(C-1){1'b0}}, 1'b1};

    logic [3:0]     state_r;
    logic [15:0]    cnt_r;
    logic [8:0]     tap_r;
    logic [8:0]     lo_r;
    logic [8:0]     hi_r;
    logic           found_r;
    logic           good_r;
    logic [3:0]     slip_cnt_r;
    logic [9:0]     word_r;
    logic           ok_r;
    logic           start_d_r;
    logic [CW-1:0]  chan_sel_r;
    logic [8:0]     delay_val_r;
    logic [2*C-1:0] delay_load_r;
    logic [C-1:0]   bitslip_r;
    logic           busy_r;
    logic           done_r;
    logic [C-1:0]   fail_mask_r;
    logic [8:0]     result_r [C];

    logic [9:0]     w_s;
    logic           same_s;
    logic           good_s;
    logic           aligned_s;
    logic           last_s;
    logic [9:0]     tap_next_s;
    logic [9:0]     sum_s;
    logic [2*C-1:0] lane_mask_s;
    logic [C-1:0]   ch_mask_s;

    // True when w is any of the ten rotations of the training pattern
    function automatic logic is_rotation(input logic [9:0] w);
        logic [9:0] r;
        logic       hit;
        r   = G_PATTERN;
        hit = 1'b0;
        for (int k = 0; k < 10; k++) begin
            hit = hit | (w == r);
            r   = {r[8:0], r[9]};
        end
        return hit;
    endfunction

    // Word comparison and sweep arithmetic for the channel under training
    always_comb begin
        w_s    = word_r;
        same_s = 1'b0;
        if (cnt_r == 16'd0) begin
            w_s    = data_in;
            same_s = 1'b1;
        end else begin
            w_s    = word_r;
            same_s = ok_r && (data_in == word_r);
        end
        good_s      = same_s && is_rotation(w_s);
        aligned_s   = same_s && (w_s == G_PATTERN);
        last_s      = data_valid && (cnt_r == CHECK_LAST);
        tap_next_s  = {1'b0, tap_r} + TAP_STEP;
        sum_s       = {1'b0, lo_r} + {1'b0, hi_r};
        lane_mask_s = LANE0 << {chan_sel_r, 1'b0};
        ch_mask_s   = CH0 << chan_sel_r;
    end

    // Training sequencer with registered outputs
    always_ff @(posedge axil_clk) begin
        if (!axil_rst_n) begin
            state_r      <= S_IDLE;
            cnt_r        <= 16'd0;
            tap_r        <= 9'd0;
            lo_r         <= 9'd0;
            hi_r         <= 9'd0;
            found_r      <= 1'b0;
            good_r       <= 1'b0;
            slip_cnt_r   <= 4'd0;
            word_r       <= 10'd0;
            ok_r         <= 1'b0;
            start_d_r    <= 1'b1;
            chan_sel_r   <= '0;
            delay_val_r  <= 9'd0;
            delay_load_r <= '0;
            bitslip_r    <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            fail_mask_r  <= '0;
            for (int i = 0; i < C; i++) result_r[i] <= 9'd0;
        end else begin
            start_d_r <= start;
            case (state_r)
                S_IDLE: begin
                    if (start && !start_d_r) begin
                        chan_sel_r  <= '0;
                        tap_r       <= 9'd0;
                        lo_r        <= 9'd0;
                        hi_r        <= 9'd0;
                        found_r     <= 1'b0;
                        slip_cnt_r  <= 4'd0;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                        fail_mask_r <= '0;
                        for (int i = 0; i < C; i++) result_r[i] <= 9'd0;
                        state_r     <= S_SET_TAP;
                    end
                end
                S_SET_TAP: begin
                    delay_val_r <= tap_r;
                    cnt_r       <= 16'd0;
                    state_r     <= S_LOAD;
                end
                S_LOAD, S_CLOAD: begin
                    if (cnt_r == PULSE_CNT) begin
                        delay_load_r <= '0;
                        cnt_r        <= 16'd0;
                        state_r      <= (state_r == S_LOAD) ? S_SETTLE : S_CSETTLE;
                    end else begin
                        delay_load_r <= lane_mask_s;
                        cnt_r        <= cnt_r + 16'd1;
                    end
                end
                S_SETTLE, S_CSETTLE, S_SSETTLE: begin
                    if (cnt_r == SETTLE_LAST) begin
                        cnt_r   <= 16'd0;
                        state_r <= (state_r == S_SETTLE) ? S_CHECK : S_ACHECK;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                S_CHECK: begin
                    if (data_valid) begin
                        word_r <= w_s;
                        ok_r   <= same_s;
                        cnt_r  <= cnt_r + 16'd1;
                        if (last_s) begin
                            good_r  <= good_s;
                            cnt_r   <= 16'd0;
                            state_r <= S_EVAL;
                        end
                    end
                end
                S_EVAL: begin
                    if (good_r) begin
                        if (!found_r) lo_r <= tap_r;
                        hi_r    <= tap_r;
                        found_r <= 1'b1;
                    end
                    // The first bad tap after a good run closes the eye
                    if ((!good_r && found_r) || (tap_next_s > 10'd511)) begin
                        state_r <= S_CENTER;
                    end else begin
                        tap_r   <= tap_next_s[8:0];
                        state_r <= S_SET_TAP;
                    end
                end
                S_CENTER: begin
                    if (!found_r) begin
                        fail_mask_r[chan_sel_r] <= 1'b1;
                        result_r[chan_sel_r]    <= 9'd0;
                        state_r                 <= S_NEXT_CH;
                    end else begin
                        result_r[chan_sel_r] <= sum_s[9:1];
                        delay_val_r          <= sum_s[9:1];
                        cnt_r                <= 16'd0;
                        state_r              <= S_CLOAD;
                    end
                end
                S_ACHECK: begin
                    if (data_valid) begin
                        word_r <= w_s;
                        ok_r   <= same_s;
                        cnt_r  <= cnt_r + 16'd1;
                        if (last_s) begin
                            cnt_r <= 16'd0;
                            if (aligned_s) begin
                                state_r <= S_NEXT_CH;
                            end else if (slip_cnt_r == 4'd10) begin
                                fail_mask_r[chan_sel_r] <= 1'b1;
                                state_r                 <= S_NEXT_CH;
                            end else begin
                                slip_cnt_r <= slip_cnt_r + 4'd1;
                                state_r    <= S_SLIP;
                            end
                        end
                    end
                end
                S_SLIP: begin
                    if (cnt_r == PULSE_CNT) begin
                        bitslip_r <= '0;
                        cnt_r     <= 16'd0;
                        state_r   <= S_SSETTLE;
                    end else begin
                        bitslip_r <= ch_mask_s;
                        cnt_r     <= cnt_r + 16'd1;
                    end
                end
                S_NEXT_CH: begin
                    if (chan_sel_r == LAST_CH) begin
                        state_r <= S_DONE;
                    end else begin
                        chan_sel_r <= chan_sel_r + CW'(1);
                        tap_r      <= 9'd0;
                        lo_r       <= 9'd0;
                        hi_r       <= 9'd0;
                        found_r    <= 1'b0;
                        slip_cnt_r <= 4'd0;
                        cnt_r      <= 16'd0;
                        state_r    <= S_SET_TAP;
                    end
                end
                S_DONE: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= S_IDLE;
                end
                default: begin
                    delay_load_r <= '0;
                    bitslip_r    <= '0;
                    busy_r       <= 1'b0;
                    state_r      <= S_IDLE;
                end
            endcase
        end
    end

    assign chan_sel   = chan_sel_r;
    assign delay_val  = delay_val_r;
    assign delay_load = delay_load_r;
    assign bitslip    = bitslip_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign fail_mask  = fail_mask_r;
    assign result_tap = result_r[result_sel];

endmodule
